// File: rtl/simd_pkg.sv
// Shared field layout, data-mode encodings and bundle type for the SIMD issue path.
package simd_pkg;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int DM_MSB   = 11;
  localparam int DM_LSB   = 9;
  localparam int IMMF_BIT = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  localparam int SIMD_W  = 256;
  localparam int SIMD_IW = 16;

  localparam logic [2:0]  DM_8     = 3'b000;
  localparam logic [2:0]  DM_16    = 3'b001;
  localparam logic [2:0]  DM_32    = 3'b010;
  localparam logic [2:0]  DM_64    = 3'b011;
  localparam logic [3:0]  OPC_NOP  = 4'b0000;
  localparam logic [15:0] NOP_INST = 16'h0000;

  typedef struct packed {
    logic [SIMD_IW-1:0] inst;
    logic [SIMD_W-1:0]  a;
    logic [SIMD_W-1:0]  b;
  } simd_bundle_t;

  // NOPs carry no data mode, so only real opcodes are screened.
  function automatic logic dm_legal(input logic [SIMD_IW-1:0] inst);
    logic [2:0] dm;
    dm = inst[DM_MSB:DM_LSB];
    return (inst[OPC_MSB:OPC_LSB] == OPC_NOP) ||
           (dm == DM_8) || (dm == DM_16) || (dm == DM_32) || (dm == DM_64);
  endfunction

endpackage

// File: rtl/simd_fifo.sv
// Generic DEPTH-entry FIFO; count disambiguates full from empty since pointers wrap.
module simd_fifo #(
  parameter int DEPTH = 4,
  parameter int BW    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [BW-1:0]                wdata,
  output logic [BW-1:0]                rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [BW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == CW'(0));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Next-state pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/simd_issue_queue.sv
// Bundle queue in front of SIMD_ALU: one issue per clock, NOP when idle, illegal data modes dropped.
module simd_issue_queue
  import simd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 256,
  parameter int IW    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IW-1:0]                in_inst,
  input  logic [W-1:0]                 in_a,
  input  logic [W-1:0]                 in_b,
  input  logic                         stall,
  output logic [IW-1:0]                alu_inst,
  output logic [W-1:0]                 alu_a,
  output logic [W-1:0]                 alu_b,
  output logic                         alu_issue,
  output logic                         illegal_dm,
  output logic [7:0]                   err_count,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int BW = IW + 2*W;

  logic [BW-1:0] wdata_s, rdata_s;
  logic          full_s, empty_s, push_s, pop_s;
  logic [IW-1:0] head_inst_s;
  logic [W-1:0]  head_a_s, head_b_s;

  logic [IW-1:0] alu_inst_q, alu_inst_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic          alu_issue_q, alu_issue_d;
  logic          illegal_dm_q, illegal_dm_d;
  logic [7:0]    err_count_q, err_count_d;

  // in_ready looks only at registered occupancy, never at stall or the pop
  assign in_ready    = !full_s;
  assign push_s      = in_valid && !full_s;
  assign pop_s       = !stall && !empty_s;
  assign wdata_s     = {in_inst, in_a, in_b};
  assign head_inst_s = rdata_s[BW-1 -: IW];
  assign head_a_s    = rdata_s[2*W-1 -: W];
  assign head_b_s    = rdata_s[W-1:0];

  simd_fifo #(.DEPTH(DEPTH), .BW(BW)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .count (count),
    .full  (full_s),
    .empty (empty_s)
  );

  // Issue selection: hold on stall, drop illegal heads, NOP when empty
  always_comb begin
    alu_inst_d   = alu_inst_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_issue_d  = alu_issue_q;
    illegal_dm_d = 1'b0;
    err_count_d  = err_count_q;
    if (stall) begin
      illegal_dm_d = 1'b0;
    end else if (pop_s && dm_legal(head_inst_s)) begin
      alu_inst_d  = head_inst_s;
      alu_a_d     = head_a_s;
      alu_b_d     = head_b_s;
      alu_issue_d = (head_inst_s[OPC_MSB:OPC_LSB] != OPC_NOP);
    end else if (pop_s) begin
      alu_inst_d   = NOP_INST;
      alu_a_d      = '0;
      alu_b_d      = '0;
      alu_issue_d  = 1'b0;
      illegal_dm_d = 1'b1;
      if (err_count_q == 8'hFF) begin
        err_count_d = 8'hFF;
      end else begin
        err_count_d = err_count_q + 8'd1;
      end
    end else begin
      alu_inst_d  = NOP_INST;
      alu_a_d     = '0;
      alu_b_d     = '0;
      alu_issue_d = 1'b0;
    end
  end

  // Issue, status and error counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_inst_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_issue_q  <= 1'b0;
      illegal_dm_q <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      alu_inst_q   <= alu_inst_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_issue_q  <= alu_issue_d;
      illegal_dm_q <= illegal_dm_d;
      err_count_q  <= err_count_d;
    end
  end

  assign alu_inst   = alu_inst_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_issue  = alu_issue_q;
  assign illegal_dm = illegal_dm_q;
  assign err_count  = err_count_q;

endmodule
